// File: rtl/rll27_encoder.sv
// rll27_encoder: streaming RLL(2,7) rate-1/2 encoder.
// Serial data bits are parsed into prefix-free words of 2..4 bits. Each
// complete word is replaced by a 4..8 bit codeword that is shifted out one
// bit per output handshake. An optional NRZI stage turns code bits into line
// levels, and sr_o keeps the most recent line bits (newest in the LSB).
module rll27_encoder #(
    parameter int unsigned SR_WIDTH = 8,
    parameter bit          NRZI     = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                data_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic                flush_i,
    output logic                code_o,
    output logic                code_valid_o,
    input  logic                code_ready_i,
    output logic [SR_WIDTH-1:0] sr_o
);

    // ------------------------------------------------------------------
    // Word recognition helpers. The parse buffer holds bits oldest-first
    // towards the MSB, so the word is bits[len-1:0] read MSB first.
    // ------------------------------------------------------------------

    // True when the buffered bits form one of the seven table words.
    function automatic logic word_complete(input logic [2:0] len,
                                           input logic [3:0] bits);
        logic r;
        r = 1'b0;
        case (len)
            3'd2:    r = bits[1];                  // 10, 11
            3'd3:    r = (bits[2:0] != 3'b001);    // 000, 010, 011 (001 is a prefix)
            3'd4:    r = 1'b1;                     // 0010, 0011
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Codeword lookup: returns {bit count, codeword MSB-aligned in 8 bits}.
    function automatic logic [11:0] codeword(input logic [2:0] len,
                                             input logic [3:0] bits);
        logic [11:0] r;
        r = 12'd0;
        case (len)
            3'd2: begin
                case (bits[1:0])
                    2'b10:   r = {4'd4, 8'b0100_0000};
                    2'b11:   r = {4'd4, 8'b1000_0000};
                    default: r = 12'd0;
                endcase
            end
            3'd3: begin
                case (bits[2:0])
                    3'b000:  r = {4'd6, 8'b0001_0000};
                    3'b010:  r = {4'd6, 8'b1001_0000};
                    3'b011:  r = {4'd6, 8'b0010_0000};
                    default: r = 12'd0;
                endcase
            end
            3'd4: begin
                case (bits[3:0])
                    4'b0010: r = {4'd8, 8'b0010_0100};
                    4'b0011: r = {4'd8, 8'b0000_1000};
                    default: r = 12'd0;
                endcase
            end
            default: r = 12'd0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]          pbuf_bits_q, pbuf_bits_d;
    logic [2:0]          pbuf_len_q,  pbuf_len_d;
    logic [7:0]          em_q,        em_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                lvl_q,       lvl_d;
    logic [SR_WIDTH-1:0] sr_q,        sr_d;

    // Combinational helpers
    logic        pbuf_full_s;
    logic [11:0] cw_s;
    logic        hs_s;
    logic        raw_s;
    logic        line_s;
    logic        load_s;
    logic        accept_s;
    logic        pad_s;

    // Decode the parse buffer and derive the handshake / load / append strobes.
    always_comb begin
        pbuf_full_s = word_complete(pbuf_len_q, pbuf_bits_q);
        cw_s        = codeword(pbuf_len_q, pbuf_bits_q);
        hs_s        = (cnt_q != 4'd0) & code_ready_i;
        raw_s       = em_q[7];
        if (NRZI) begin
            line_s = lvl_q ^ raw_s;
        end else begin
            line_s = raw_s;
        end
        // The emitter is free for a new word when idle, or when its last bit
        // leaves this cycle, which keeps back-to-back codewords gapless.
        load_s   = pbuf_full_s &
                   ((cnt_q == 4'd0) | ((cnt_q == 4'd1) & hs_s));
        // A complete word blocks input, so accept and load never coincide.
        accept_s = data_valid_i & ~pbuf_full_s;
        // Flush pads a partial word with zeros; real data always wins.
        pad_s    = flush_i & ~data_valid_i & (pbuf_len_q != 3'd0) & ~pbuf_full_s;
    end

    // Parse buffer next state: clear on load, otherwise append data or a pad zero.
    always_comb begin
        pbuf_bits_d = pbuf_bits_q;
        pbuf_len_d  = pbuf_len_q;
        if (load_s) begin
            pbuf_bits_d = 4'd0;
            pbuf_len_d  = 3'd0;
        end else if (accept_s) begin
            pbuf_bits_d = {pbuf_bits_q[2:0], data_i};
            pbuf_len_d  = pbuf_len_q + 3'd1;
        end else if (pad_s) begin
            pbuf_bits_d = {pbuf_bits_q[2:0], 1'b0};
            pbuf_len_d  = pbuf_len_q + 3'd1;
        end else begin
            pbuf_bits_d = pbuf_bits_q;
            pbuf_len_d  = pbuf_len_q;
        end
    end

    // Emitter next state: load a fresh codeword, or shift one bit out per handshake.
    always_comb begin
        em_d  = em_q;
        cnt_d = cnt_q;
        if (load_s) begin
            em_d  = cw_s[7:0];
            cnt_d = cw_s[11:8];
        end else if (hs_s) begin
            em_d  = {em_q[6:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end else begin
            em_d  = em_q;
            cnt_d = cnt_q;
        end
    end

    // Line level and snapshot register advance only when a bit is handed off.
    always_comb begin
        lvl_d = lvl_q;
        sr_d  = sr_q;
        if (hs_s) begin
            lvl_d   = line_s;
            sr_d    = sr_q << 1'b1;
            sr_d[0] = line_s;
        end else begin
            lvl_d = lvl_q;
            sr_d  = sr_q;
        end
    end

    // State registers with synchronous reset discarding any pending word or codeword.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pbuf_bits_q <= 4'd0;
            pbuf_len_q  <= 3'd0;
            em_q        <= 8'd0;
            cnt_q       <= 4'd0;
            lvl_q       <= 1'b0;
            sr_q        <= '0;
        end else begin
            pbuf_bits_q <= pbuf_bits_d;
            pbuf_len_q  <= pbuf_len_d;
            em_q        <= em_d;
            cnt_q       <= cnt_d;
            lvl_q       <= lvl_d;
            sr_q        <= sr_d;
        end
    end

    // Outputs are decoded straight from flops only.
    assign data_ready_o = ~pbuf_full_s;
    assign code_valid_o = (cnt_q != 4'd0);
    assign code_o       = line_s;
    assign sr_o         = sr_q;

endmodule
